xmodem_loader: RTL and testbench
================================

XMODEM_LOADER -- requirements
Module: xmodem_loader

Interface
REQ-001 Parameter NB_UART_DATA, 8, UART byte width.
REQ-002 Parameter NB_INSTRUCTION, 32, instruction memory word width.
REQ-003 Parameter IMEM_ADDR_WIDTH, 7, instruction memory byte-address width.
REQ-004 Parameter TIMEOUT_CYCLES, 1000000, idle cycles allowed between bytes inside a block.
REQ-005 Parameter MAX_RETRY, 10, consecutive NAKs before abort.
REQ-006 Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock.
- i_rst  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle pulse that begins a transfer.
- i_uart_rx_data  in  NB_UART_DATA  head of the UART RX FIFO (show-ahead).
- i_uart_rx_empty  in  1  RX FIFO empty.
- o_uart_rd  out  1  one-cycle pop of the RX FIFO head.
- o_uart_wr  out  1  one-cycle push of o_uart_wdata into the TX FIFO.
- o_uart_wdata  out  NB_UART_DATA  response byte.
- o_uart_tx_start  out  1  one-cycle transmit trigger.
- i_uart_tx_done  in  1  transmit complete pulse.
- o_imem_we  out  1  instruction memory word write strobe.
- o_imem_addr  out  IMEM_ADDR_WIDTH  word-aligned byte address.
- o_imem_wdata  out  NB_INSTRUCTION  assembled word.
- o_busy  out  1  transfer in progress.
- o_done  out  1  one-cycle pulse after EOT is ACKed.
- o_error  out  1  sticky abort flag; cleared by i_start.

Function
REQ-007 States: IDLE, WAIT_HDR, GET_BLK, GET_NBLK, GET_DATA, GET_CKSUM, CHECK, SEND, WAIT_TX, FINISH.
REQ-008 IDLE: i_start -> clear error, set expected block = 1 and retry count = 0, queue NAK (0x15) -> SEND.
REQ-009 SEND: assert o_uart_wr with o_uart_wdata = queued byte for 1 cycle; assert o_uart_tx_start on the next cycle; then go to WAIT_TX.
REQ-010 WAIT_TX: on i_uart_tx_done, return to the state recorded when the byte was queued.
REQ-011 A byte is consumed only when i_uart_rx_empty = 0; o_uart_rd pulses in the same cycle the byte is registered. There is never more than one pop per cycle.
REQ-012 WAIT_HDR responses:
- 0x01 -> GET_BLK.
- 0x04 -> queue ACK (0x06), then FINISH.
- 0x18 -> set o_error, then IDLE.
- Any other byte is discarded.
REQ-013 GET_BLK and GET_NBLK each capture one byte. The checksum is an 8-bit modulo-256 sum of the 128 data bytes only.
REQ-014 GET_DATA receives 128 bytes assembled little-endian (the first byte goes to [7:0]). o_imem_we pulses 1 cycle after the 4th byte of each word is popped.
REQ-015 Write address = ((blk-1)*128 + byte_index) with the low 2 bits cleared, taken modulo 2^IMEM_ADDR_WIDTH (wrap-around).
REQ-016 Writes are suppressed when the received block number equals expected-1 (duplicate) or when blk + nblk != 0xFF.
REQ-017 CHECK outcomes:
- Valid block (blk = expected, nblk = ~blk, checksum matches): ACK, expected+1 (wraps 255->0), retry count = 0.
- Duplicate block with matching checksum: ACK, expected unchanged.
- Otherwise: NAK, retry count + 1.
REQ-018 A failed block retransmits to the same addresses. Data already written is overwritten; it is not rolled back.
REQ-019 No RX byte for TIMEOUT_CYCLES in GET_BLK..GET_CKSUM: flush the partial block, NAK, retry count + 1, then WAIT_HDR.
REQ-020 When the retry count reaches MAX_RETRY: queue CAN (0x18), set o_error, then IDLE.
REQ-021 FINISH: pulse o_done for 1 cycle, then IDLE.
REQ-022 o_busy = 1 in every state except IDLE.
REQ-023 i_start is ignored while o_busy = 1.
REQ-024 When an RX byte and i_uart_tx_done arrive in the same cycle, the byte stays in the FIFO until the FSM reaches a receive state.

Reset
REQ-025 While i_rst = 0:
- State = IDLE.
- All strobes, o_busy, o_done and o_error = 0.
- o_uart_wdata, o_imem_addr and o_imem_wdata = 0.
- Counters are cleared.
REQ-026 Reset asserted mid-block abandons the transfer. No further imem writes occur after reset is released.

Structure
REQ-027 The shared package holds the SOH/EOT/ACK/NAK/CAN byte constants, the block size (128) and the state encoding.
REQ-028 One sub-module, xmodem_word_packer, holds the byte-to-word shift register, the byte index and the write strobe.

Verification
REQ-029 Scenario: start, then SOH, 0x01, 0xFE, 20 addi words plus 48 bytes of 0x1A, correct checksum -> 32 writes at 0x00..0x7C, TX 0x15 then 0x06.
REQ-030 Scenario: the same block with checksum+1 -> TX 0x15 and no o_done; then resend it correct -> 0x06, writes repeated at 0x00..0x7C.
REQ-031 Scenario: block 1 accepted, then block 1 resent -> 0x06, zero imem writes; then EOT -> 0x06 and a single o_done pulse.
REQ-032 Scenario: header 0x01, 0x01, 0xFF -> 0x15; 10 consecutive bad blocks -> 0x18, o_error = 1, o_busy = 0.
REQ-033 Scenario: RX stalls mid-data for TIMEOUT_CYCLES -> 0x15, state WAIT_HDR, and the next good block is accepted.
REQ-034 Scenario: i_rst = 0 after 50 data bytes -> all outputs 0 within 1 cycle and no writes afterward.

Source files
------------

// File: rtl/xmodem_pkg.sv
// xmodem_pkg: XMODEM protocol byte codes, block size and loader state encoding
package xmodem_pkg;
    localparam logic [7:0] SOH = 8'h01;
    localparam logic [7:0] EOT = 8'h04;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;
    localparam logic [7:0] CAN = 8'h18;
    localparam int BLOCK_SIZE = 128;
    typedef enum logic [3:0] {
        IDLE, WAIT_HDR, GET_BLK, GET_NBLK, GET_DATA, GET_CKSUM, CHECK, SEND, WAIT_TX, FINISH
    } state_t;
endpackage

// File: rtl/xmodem_word_packer.sv
// xmodem_word_packer: little-endian byte-to-word assembly with block byte index and write strobe
module xmodem_word_packer
    import xmodem_pkg::*;
#(
    parameter int NB_UART_DATA   = 8,
    parameter int NB_INSTRUCTION = 32
) (
    input  logic                                clk,
    input  logic                                i_rst,
    input  logic                                i_clear,
    input  logic                                i_valid,
    input  logic                                i_wr_en,
    input  logic [NB_UART_DATA-1:0]             i_byte,
    output logic                                o_last,
    output logic                                o_we,
    output logic [NB_INSTRUCTION-1:0]           o_word,
    output logic [$clog2(BLOCK_SIZE)-1:0]       o_word_idx
);
    localparam int BPW   = NB_INSTRUCTION / NB_UART_DATA;
    localparam int BPW_W = $clog2(BPW);
    localparam int IDX_W = $clog2(BLOCK_SIZE);

    logic [IDX_W-1:0]          r_idx;
    logic [NB_INSTRUCTION-1:0] r_shift;
    logic                      r_we;
    logic [IDX_W-1:0]          w_prev;

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            r_idx   <= '0;
            r_shift <= '0;
            r_we    <= 1'b0;
        end else begin
            r_we <= i_valid & i_wr_en & (r_idx[BPW_W-1:0] == BPW_W'(BPW - 1));
            if (i_clear) begin
                r_idx <= '0;
            end else if (i_valid) begin
                r_idx   <= r_idx + 1'b1;
                r_shift <= {i_byte, r_shift[NB_INSTRUCTION-1:NB_UART_DATA]};
            end
        end
    end

    // index has already advanced past the word's last byte when the strobe fires
    assign w_prev     = r_idx - 1'b1;
    assign o_word_idx = {w_prev[IDX_W-1:BPW_W], BPW_W'(0)};
    assign o_last     = r_idx == IDX_W'(BLOCK_SIZE - 1);
    assign o_we       = r_we;
    assign o_word     = r_shift;
endmodule

// File: rtl/xmodem_loader.sv
// xmodem_loader: XMODEM-checksum receiver that writes 128-byte blocks into instruction memory
module xmodem_loader
    import xmodem_pkg::*;
#(
    parameter int NB_UART_DATA    = 8,
    parameter int NB_INSTRUCTION  = 32,
    parameter int IMEM_ADDR_WIDTH = 7,
    parameter int TIMEOUT_CYCLES  = 1000000,
    parameter int MAX_RETRY       = 10
) (
    input  logic                       clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic [NB_UART_DATA-1:0]    i_uart_rx_data,
    input  logic                       i_uart_rx_empty,
    output logic                       o_uart_rd,
    output logic                       o_uart_wr,
    output logic [NB_UART_DATA-1:0]    o_uart_wdata,
    output logic                       o_uart_tx_start,
    input  logic                       i_uart_tx_done,
    output logic                       o_imem_we,
    output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
    output logic [NB_INSTRUCTION-1:0]  o_imem_wdata,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_error
);
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW    = $clog2(MAX_RETRY + 1);
    localparam int IDX_W = $clog2(BLOCK_SIZE);
    localparam int AFW   = NB_UART_DATA + IDX_W;
    typedef logic [NB_UART_DATA-1:0] byte_t;

    state_t            r_state, w_next, r_ret, w_q_ret;
    logic              r_phase, r_error;
    byte_t             r_tx_byte, w_q_byte, r_blk, r_nblk, r_cksum, r_sum, r_expect;
    logic [RW-1:0]     r_retry;
    logic [RW:0]       w_retry_inc;
    logic [TW-1:0]     r_idle;
    logic              w_data_state, w_rd, w_timeout, w_q, w_fail, w_ok, w_init, w_clear, w_err_set;
    logic              w_hdr_ok, w_dup, w_sum_ok, w_last, w_pk_we;
    logic [IDX_W-1:0]  w_word_idx;
    logic [AFW-1:0]    w_addr_full;

    assign w_data_state = r_state inside {GET_BLK, GET_NBLK, GET_DATA, GET_CKSUM};
    assign w_rd         = (w_data_state | (r_state == WAIT_HDR)) & ~i_uart_rx_empty;
    assign w_timeout    = w_data_state & i_uart_rx_empty & (r_idle == TW'(TIMEOUT_CYCLES - 1));
    assign w_hdr_ok     = byte_t'(r_blk + r_nblk) == '1;
    assign w_dup        = r_blk == byte_t'(r_expect - 1'b1);
    assign w_sum_ok     = r_sum == r_cksum;
    assign w_retry_inc  = {1'b0, r_retry} + 1'b1;

    always_comb begin
        w_next          = r_state;
        w_q             = 1'b0;
        w_q_byte        = byte_t'(NAK);
        w_q_ret         = WAIT_HDR;
        w_fail          = w_timeout;
        w_clear         = w_timeout;
        w_ok            = 1'b0;
        w_init          = 1'b0;
        w_err_set       = 1'b0;
        o_uart_wr       = 1'b0;
        o_uart_tx_start = 1'b0;
        o_done          = 1'b0;
        case (r_state)
            IDLE: begin
                w_init = i_start;
                w_q    = i_start;
            end
            WAIT_HDR: if (w_rd) begin
                if (i_uart_rx_data == byte_t'(SOH)) begin
                    w_next  = GET_BLK;
                    w_clear = 1'b1;
                end else if (i_uart_rx_data == byte_t'(EOT)) begin
                    w_q      = 1'b1;
                    w_q_byte = byte_t'(ACK);
                    w_q_ret  = FINISH;
                end else if (i_uart_rx_data == byte_t'(CAN)) begin
                    w_err_set = 1'b1;
                    w_next    = IDLE;
                end
            end
            GET_BLK:   if (w_rd) w_next = GET_NBLK;
            GET_NBLK:  if (w_rd) w_next = GET_DATA;
            GET_DATA:  if (w_rd && w_last) w_next = GET_CKSUM;
            GET_CKSUM: if (w_rd) w_next = CHECK;
            CHECK: begin
                w_ok     = w_hdr_ok & w_sum_ok & (r_blk == r_expect);
                w_q      = w_hdr_ok & w_sum_ok & ((r_blk == r_expect) | w_dup);
                w_q_byte = byte_t'(ACK);
                w_fail   = ~w_q;
            end
            SEND: begin
                o_uart_wr       = ~r_phase;
                o_uart_tx_start = r_phase;
                if (r_phase) w_next = WAIT_TX;
            end
            WAIT_TX: if (i_uart_tx_done) w_next = r_ret;
            FINISH: begin
                o_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (w_fail) begin
            w_q      = 1'b1;
            w_q_byte = byte_t'(NAK);
            if (w_retry_inc >= (RW + 1)'(MAX_RETRY)) begin
                w_q_byte  = byte_t'(CAN);
                w_q_ret   = IDLE;
                w_err_set = 1'b1;
            end
        end
        if (w_q) w_next = SEND;
    end

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state   <= IDLE;
            r_ret     <= IDLE;
            r_phase   <= 1'b0;
            r_error   <= 1'b0;
            r_tx_byte <= '0;
            r_blk     <= '0;
            r_nblk    <= '0;
            r_cksum   <= '0;
            r_sum     <= '0;
            r_expect  <= '0;
            r_retry   <= '0;
            r_idle    <= '0;
        end else begin
            r_state <= w_next;
            r_phase <= (r_state == SEND) & ~r_phase;
            r_idle  <= (w_data_state & ~w_rd) ? r_idle + 1'b1 : '0;
            if (w_q) begin
                r_tx_byte <= w_q_byte;
                r_ret     <= w_q_ret;
            end
            if (w_init) begin
                r_expect <= byte_t'(1);
                r_retry  <= '0;
            end else if (w_ok) begin
                r_expect <= r_expect + 1'b1;
                r_retry  <= '0;
            end else if (w_fail) begin
                r_retry <= w_retry_inc[RW-1:0];
            end
            if (w_init) r_error <= 1'b0;
            else if (w_err_set) r_error <= 1'b1;
            if (w_rd && r_state == GET_BLK) r_blk <= i_uart_rx_data;
            if (w_rd && r_state == GET_NBLK) r_nblk <= i_uart_rx_data;
            if (w_rd && r_state == GET_CKSUM) r_cksum <= i_uart_rx_data;
            if (w_clear) r_sum <= '0;
            else if (w_rd && r_state == GET_DATA) r_sum <= r_sum + i_uart_rx_data;
        end
    end

    xmodem_word_packer #(
        .NB_UART_DATA  (NB_UART_DATA),
        .NB_INSTRUCTION(NB_INSTRUCTION)
    ) u_packer (
        .clk       (clk),
        .i_rst     (i_rst),
        .i_clear   (w_clear),
        .i_valid   (w_rd & (r_state == GET_DATA)),
        .i_wr_en   (w_hdr_ok & ~w_dup),
        .i_byte    (i_uart_rx_data),
        .o_last    (w_last),
        .o_we      (w_pk_we),
        .o_word    (o_imem_wdata),
        .o_word_idx(w_word_idx)
    );

    assign w_addr_full  = {byte_t'(r_blk - 1'b1), IDX_W'(0)} + AFW'(w_word_idx);
    assign o_imem_we    = w_pk_we;
    assign o_imem_addr  = w_pk_we ? IMEM_ADDR_WIDTH'(w_addr_full) : '0;
    assign o_uart_rd    = w_rd;
    assign o_uart_wdata = r_tx_byte;
    assign o_busy       = r_state != IDLE;
    assign o_error      = r_error;
endmodule

// File: tb/tb_xmodem_loader.sv
// tb_xmodem_loader: table-driven and scenario checks of xmodem_loader against a protocol-level model
module tb_xmodem_loader;
    localparam int TO = 300;

    logic        clk = 1'b0, i_rst = 1'b0, i_start = 1'b0;
    logic [7:0]  i_uart_rx_data = 8'h00;
    logic        i_uart_rx_empty = 1'b1, i_uart_tx_done = 1'b0;
    logic        o_uart_rd, o_uart_wr, o_uart_tx_start, o_imem_we, o_busy, o_done, o_error;
    logic [7:0]  o_uart_wdata;
    logic [6:0]  o_imem_addr;
    logic [31:0] o_imem_wdata;

    typedef struct {logic [6:0] a; logic [31:0] d;} wr_t;
    typedef struct {logic [7:0] blk; logic [7:0] nblk; logic [7:0] dlt; logic [7:0] resp; int nwr;} vec_t;

    logic [7:0] rxq[$], tx_log[$], exp_tx[$];
    wr_t        wr_log[$], exp_wr[$];
    int         total = 0, bad = 0, done_cnt = 0, tx_cnt = 0;
    bit         s_rd = 0, s_tx = 0;
    logic [7:0] m_expect = 8'd1;
    int         m_retry = 0;
    vec_t       tab[9];

    always #5 clk = ~clk;

    xmodem_loader #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .i_rst(i_rst), .i_start(i_start),
        .i_uart_rx_data(i_uart_rx_data), .i_uart_rx_empty(i_uart_rx_empty), .o_uart_rd(o_uart_rd),
        .o_uart_wr(o_uart_wr), .o_uart_wdata(o_uart_wdata), .o_uart_tx_start(o_uart_tx_start),
        .i_uart_tx_done(i_uart_tx_done), .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr),
        .o_imem_wdata(o_imem_wdata), .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
    );

    always @(negedge clk) begin
        s_rd = o_uart_rd;
        s_tx = o_uart_tx_start;
        if (o_uart_wr) tx_log.push_back(o_uart_wdata);
        if (o_imem_we) wr_log.push_back('{o_imem_addr, o_imem_wdata});
        if (o_done) done_cnt++;
    end

    // show-ahead RX FIFO and a TX that completes three cycles after its trigger
    always @(posedge clk) begin
        #1;
        if (s_rd && rxq.size() > 0) void'(rxq.pop_front());
        s_rd = 0;
        i_uart_tx_done = 1'b0;
        if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) i_uart_tx_done = 1'b1;
        end
        if (s_tx) begin
            tx_cnt = 3;
            s_tx = 0;
        end
        i_uart_rx_empty = rxq.size() == 0;
        i_uart_rx_data  = rxq.size() > 0 ? rxq[0] : 8'h00;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    task automatic check_zero(input string nm);
        chk({nm, " busy"}, o_busy, 0);
        chk({nm, " done"}, o_done, 0);
        chk({nm, " error"}, o_error, 0);
        chk({nm, " rd"}, o_uart_rd, 0);
        chk({nm, " wr"}, o_uart_wr, 0);
        chk({nm, " txstart"}, o_uart_tx_start, 0);
        chk({nm, " we"}, o_imem_we, 0);
        chk({nm, " wdata"}, o_uart_wdata, 0);
        chk({nm, " addr"}, o_imem_addr, 0);
        chk({nm, " imem_wdata"}, o_imem_wdata, 0);
    endtask

    task automatic pulse_start();
        @(negedge clk) i_start = 1'b1;
        @(negedge clk) i_start = 1'b0;
    endtask

    task automatic wait_tx(input string nm, input int n);
        int c = 0;
        while (tx_log.size() < n && c < 3000) begin
            @(negedge clk);
            c++;
        end
        chk({nm, " tx count"}, tx_log.size(), n);
    endtask

    task automatic wait_idle(input string nm);
        int c = 0;
        while (o_busy && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk({nm, " idle"}, o_busy, 0);
    endtask

    task automatic wait_rx_drained();
        int c = 0;
        while (rxq.size() > 0 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_logs(input string nm);
        chk({nm, " nwrites"}, wr_log.size(), exp_wr.size());
        for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++) begin
            chk($sformatf("%s addr[%0d]", nm, i), wr_log[i].a, exp_wr[i].a);
            chk($sformatf("%s data[%0d]", nm, i), wr_log[i].d, exp_wr[i].d);
        end
        chk({nm, " ntx"}, tx_log.size(), exp_tx.size());
        for (int i = 0; i < tx_log.size() && i < exp_tx.size(); i++)
            chk($sformatf("%s tx[%0d]", nm, i), tx_log[i], exp_tx[i]);
        wr_log.delete(); exp_wr.delete(); tx_log.delete(); exp_tx.delete();
    endtask

    task automatic begin_transfer(input string nm);
        pulse_start();
        m_expect = 8'd1;
        m_retry  = 0;
        exp_tx.push_back(8'h15);
        wait_tx(nm, 1);
        check_logs(nm);
    endtask

    // queue SOH, header and n random data bytes (plus checksum when n = 128) and model the outcome
    task automatic send_block(input logic [7:0] blk, input logic [7:0] nblk, input logic [7:0] dlt, input int n);
        logic [7:0] d[128];
        logic [7:0] sum = 8'h00;
        bit hdr_ok, dup, ck_ok;
        for (int i = 0; i < 128; i++) begin
            d[i] = 8'($urandom);
            sum  = sum + d[i];
        end
        rxq.push_back(8'h01);
        rxq.push_back(blk);
        rxq.push_back(nblk);
        for (int i = 0; i < n; i++) rxq.push_back(d[i]);
        hdr_ok = (int'(blk) + int'(nblk)) % 256 == 255;
        dup    = int'(blk) == (int'(m_expect) + 255) % 256;
        if (hdr_ok && !dup)
            for (int w = 0; w < n / 4; w++)
                exp_wr.push_back('{7'(((int'(blk) + 255) * 128 + 4 * w) % 128),
                                   {d[4*w+3], d[4*w+2], d[4*w+1], d[4*w]}});
        if (n == 128) begin
            rxq.push_back(sum + dlt);
            ck_ok = dlt == 8'h00;
            if (hdr_ok && ck_ok && blk == m_expect) begin
                exp_tx.push_back(8'h06);
                m_expect = 8'((int'(m_expect) + 1) % 256);
                m_retry  = 0;
            end else if (hdr_ok && ck_ok && dup) begin
                exp_tx.push_back(8'h06);
            end else begin
                m_retry++;
                exp_tx.push_back(m_retry >= 10 ? 8'h18 : 8'h15);
            end
        end
    endtask

    initial begin
        tab[0] = '{8'h01, 8'hFE, 8'h00, 8'h06, 32};
        tab[1] = '{8'h02, 8'hFD, 8'h01, 8'h15, 32};
        tab[2] = '{8'h02, 8'hFD, 8'h00, 8'h06, 32};
        tab[3] = '{8'h02, 8'hFD, 8'h00, 8'h06, 0};
        tab[4] = '{8'h03, 8'hFF, 8'h00, 8'h15, 0};
        tab[5] = '{8'h01, 8'hFE, 8'h00, 8'h15, 32};
        tab[6] = '{8'h03, 8'hFC, 8'h00, 8'h06, 32};
        tab[7] = '{8'h00, 8'hFF, 8'h00, 8'h15, 32};
        tab[8] = '{8'h04, 8'hFB, 8'h00, 8'h06, 32};

        repeat (3) @(negedge clk);
        check_zero("reset");
        i_rst = 1'b1;
        repeat (2) @(negedge clk);

        begin_transfer("start");
        for (int i = 0; i < 9; i++) begin
            pulse_start();
            send_block(tab[i].blk, tab[i].nblk, tab[i].dlt, 128);
            wait_tx($sformatf("vec%0d", i), exp_tx.size());
            chk($sformatf("vec%0d resp", i), tx_log.size() > 0 ? tx_log[$] : 8'hxx, tab[i].resp);
            chk($sformatf("vec%0d nwr", i), wr_log.size(), tab[i].nwr);
            check_logs($sformatf("vec%0d", i));
        end
        rxq.push_back(8'h04);
        exp_tx.push_back(8'h06);
        wait_tx("eot", 1);
        wait_idle("eot");
        check_logs("eot");
        chk("eot done pulses", done_cnt, 1);

        begin_transfer("abort start");
        for (int i = 0; i < 10; i++) send_block(8'h01, 8'h01, 8'h00, 128);
        wait_tx("abort", 10);
        wait_idle("abort");
        check_logs("abort");
        chk("abort error", o_error, 1);
        pulse_start();
        chk("start clears error", o_error, 0);
        exp_tx.push_back(8'h15);
        wait_tx("restart", 1);
        rxq.push_back(8'h18);
        wait_idle("can rx");
        chk("can rx error", o_error, 1);
        check_logs("can rx");

        begin_transfer("timeout start");
        send_block(8'h01, 8'hFE, 8'h00, 50);
        wait_rx_drained();
        repeat (TO / 2) @(negedge clk);
        chk("no early timeout", tx_log.size(), 0);
        m_retry++;
        exp_tx.push_back(8'h15);
        wait_tx("timeout", 1);
        check_logs("timeout");
        send_block(8'h01, 8'hFE, 8'h00, 128);
        wait_tx("after timeout", 1);
        check_logs("after timeout");
        chk("done after abort paths", done_cnt, 1);

        send_block(8'h02, 8'hFD, 8'h00, 50);
        wait_rx_drained();
        check_logs("pre reset");
        i_rst = 1'b0;
        #1;
        check_zero("mid reset");
        repeat (2) @(negedge clk);
        i_rst = 1'b1;
        for (int i = 0; i < 79; i++) rxq.push_back(8'($urandom));
        repeat (300) @(negedge clk);
        chk("post reset writes", wr_log.size(), 0);
        chk("post reset tx", tx_log.size(), 0);
        chk("post reset busy", o_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
